// File: rtl/rom_template_sad_reader_if.sv
// Feature-stream handshake and template-ROM read port seen by the SAD reader.
// master = reader side, slave = feature source plus ROM.
interface rom_template_sad_reader_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  feat_valid;
  logic [DATA_WIDTH-1:0] feat_data;
  logic                  feat_ready;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rd_data;

  modport master (
    input  feat_valid, feat_data, rom_rd_data,
    output feat_ready, rom_addr
  );

  modport slave (
    output feat_valid, feat_data, rom_rd_data,
    input  feat_ready, rom_addr
  );
endinterface

// File: rtl/rom_template_sad_reader.sv
// Streams feature bytes against a template ROM (1-cycle registered read),
// accumulates the sum of absolute differences and flags a threshold match.
module rom_template_sad_reader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 2048,
  parameter int unsigned SAD_WIDTH  = 19,
  parameter int unsigned THRESHOLD  = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  rom_template_sad_reader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_WIDTH-1:0]   sad,
  output logic                   match
);

  localparam int unsigned         DIFF_WIDTH = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [SAD_WIDTH:0]  THRESH     = (SAD_WIDTH + 1)'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FINISH} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [SAD_WIDTH-1:0]    acc;
  logic                    feat_ready_q;
  logic                    fire;
  logic [DIFF_WIDTH-1:0]   diff_raw;
  logic [DIFF_WIDTH-1:0]   diff_abs;

  assign bus.feat_ready = feat_ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over fire and FINISH
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   state_nxt = abort ? IDLE : RUN;
      RUN: begin
        if (abort)                         state_nxt = IDLE;
        else if (fire && idx == LAST_IDX)  state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: look-ahead ROM address keeps one byte per cycle throughput
  always_comb begin
    fire         = (state == RUN) && bus.feat_valid && feat_ready_q && !abort;
    done         = (state == FINISH) && !abort;
    bus.rom_addr = idx;
    if (fire && idx != LAST_IDX) bus.rom_addr = idx + ADDR_WIDTH'(1);
    diff_raw     = {1'b0, bus.rom_rd_data} - {1'b0, bus.feat_data};
    diff_abs     = diff_raw[DIFF_WIDTH-1] ? -diff_raw : diff_raw;
  end

  // Datapath: index, accumulator, result and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      acc          <= '0;
      feat_ready_q <= 1'b0;
      busy         <= 1'b0;
      sad          <= '0;
      match        <= 1'b0;
    end else begin
      feat_ready_q <= (state_nxt == RUN);
      busy         <= (state_nxt != IDLE);
      if (state == IDLE && start) begin
        idx <= '0;
        acc <= '0;
      end
      if (fire) begin
        acc <= acc + SAD_WIDTH'(diff_abs);
        if (idx != LAST_IDX) idx <= idx + ADDR_WIDTH'(1);
      end
      if (done) begin
        sad   <= acc;
        match <= ({1'b0, acc} < THRESH);
      end
    end
  end

endmodule

// File: tb/tb_rom_template_sad_reader.sv
// Bench for rom_template_sad_reader: table of full passes plus abort, async
// reset and start-during-busy sequences, results checked via a scoreboard.
module tb_rom_template_sad_reader;

  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 8;
  localparam int unsigned LEN = 2048;
  localparam int unsigned SW  = 19;
  localparam int unsigned THR = 65536;
  localparam int          KILL_ABORT = 1;
  localparam int          KILL_RESET = 2;

  typedef struct {
    logic [SW-1:0] sad;
    logic          match;
  } exp_t;

  typedef struct {
    int            rom_mode;
    logic [DW-1:0] feat;
    bit            rand_valid;
    logic [SW-1:0] exp_sad;
    logic          exp_match;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [SW-1:0] sad;
  logic          match;

  logic [DW-1:0] rom_mem [LEN];
  exp_t          sb[$];
  vec_t          vecs[4];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  rom_template_sad_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_template_sad_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(LEN), .SAD_WIDTH(SW), .THRESHOLD(THR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .sad   (sad),
    .match (match)
  );

  // Template ROM model: registered read, no output register
  always @(posedge clk) bus.rom_rd_data <= rom_mem[bus.rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int k = 0; k < LEN; k++)
      case (mode)
        0:       rom_mem[k] = 8'h80;
        1:       rom_mem[k] = 8'(k);
        default: rom_mem[k] = 8'h00;
      endcase
  endtask

  // One pass; kill_at >= 0 aborts or resets after that many accepted bytes.
  task automatic run_pass(input logic [DW-1:0] feat, input bit rand_valid,
                          input int kill_at, input int kill_kind,
                          input bit spam_start, input bit chk_latency, input exp_t e);
    int   cyc = 0;
    int   n = 0;
    int   seq_err = 0;
    int   d_cnt = 0;
    bit   fire;
    bit   seen = 1'b0;
    exp_t got;
    logic [DW-1:0] want;

    if (kill_at < 0) sb.push_back(e);
    start = 1'b1;
    bus.feat_valid = 1'b0;
    step();
    cyc = 1;
    start = spam_start;
    while (cyc < 10000) begin
      if (done) begin seen = 1'b1; break; end
      if (kill_at >= 0 && n == kill_at) break;
      bus.feat_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.feat_data  = feat;
      #1;
      fire = bus.feat_valid && bus.feat_ready;
      if (bus.feat_ready) begin
        want = (n < int'(LEN)) ? rom_mem[n] : 'x;
        if (bus.rom_rd_data !== want) seq_err++;
        if (bus.rom_addr !== AW'((fire && n != int'(LEN) - 1) ? n + 1 : n)) seq_err++;
      end
      if (fire) n++;
      step();
      cyc++;
    end
    check("addr_seq_errors", 32'(seq_err), 32'd0);

    if (kill_at >= 0 && kill_kind == KILL_ABORT) begin
      abort = 1'b1;
      bus.feat_valid = 1'b1;
      step();
      abort = 1'b0;
      bus.feat_valid = 1'b0;
      check("abort_busy_drop", 32'(busy), 32'd0);
      check("abort_ready_drop", 32'(bus.feat_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (done) d_cnt++;
        step();
      end
      check("abort_no_done", 32'(d_cnt), 32'd0);
      check("abort_sad_held", 32'(sad), 32'(e.sad));
      check("abort_match_held", 32'(match), 32'(e.match));
    end else if (kill_at >= 0) begin
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(bus.feat_ready), 32'd0);
      check("rst_sad", 32'(sad), 32'd0);
      check("rst_match", 32'(match), 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      #2;
      rst_n = 1'b1;
      bus.feat_valid = 1'b0;
      step();
    end else if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 10000 cycles");
      start = 1'b0;
      bus.feat_valid = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      check("byte_count", 32'(n), 32'(LEN));
      if (chk_latency) check("done_latency", 32'(cyc), 32'(LEN + 2));
      check("ready_low_at_done", 32'(bus.feat_ready), 32'd0);
      check("busy_at_done", 32'(busy), 32'd1);
      step();
      start = 1'b0;
      bus.feat_valid = 1'b0;
      got = sb.pop_front();
      check("sad", 32'(sad), 32'(got.sad));
      check("match", 32'(match), 32'(got.match));
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      if (spam_start) begin
        step();
        check("start_at_done_ignored", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'h80, 1'b0, 19'd0,      1'b1};
    vecs[1] = '{1, 8'hFF, 1'b0, 19'd261120, 1'b0};
    vecs[2] = '{1, 8'hFF, 1'b1, 19'd261120, 1'b0};
    vecs[3] = '{2, 8'hFF, 1'b0, 19'd522240, 1'b0};

    bus.feat_valid = 1'b0;
    bus.feat_data  = '0;
    fill_rom(0);
    repeat (3) step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(bus.feat_ready), 32'd0);
    check("reset_sad", 32'(sad), 32'd0);
    check("reset_match", 32'(match), 32'd0);
    check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst_n = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_ignored", 32'(busy), 32'd0);

    for (int v = 0; v < 4; v++) begin
      fill_rom(vecs[v].rom_mode);
      run_pass(vecs[v].feat, vecs[v].rand_valid, -1, 0, 1'b0, !vecs[v].rand_valid,
               '{vecs[v].exp_sad, vecs[v].exp_match});
      repeat (2) step();
    end

    // Abort mid-run after a zero-SAD pass, then a clean pass
    fill_rom(0);
    run_pass(8'h80, 1'b0, -1, 0, 1'b0, 1'b1, '{19'd0, 1'b1});
    run_pass(8'h80, 1'b0, 1000, KILL_ABORT, 1'b0, 1'b0, '{19'd0, 1'b1});
    fill_rom(1);
    run_pass(8'hFF, 1'b0, -1, 0, 1'b0, 1'b1, '{19'd261120, 1'b0});

    // Async reset mid-run, then a full pass with start held high throughout
    run_pass(8'hFF, 1'b1, 500, KILL_RESET, 1'b0, 1'b0, '{19'd0, 1'b0});
    fill_rom(2);
    run_pass(8'hFF, 1'b0, -1, 0, 1'b1, 1'b1, '{19'd522240, 1'b0});

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
